// File: rtl/cla_16bit_ripple.sv
// cla_16bit_ripple: registered 16-bit adder of four 4-bit lookahead slices with rippled slice carries; `CLA_OVERFLOW_EN adds ovf
module cla_4bit_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic       c4
);
  logic [3:0] g, p;
  logic c1, c2, c3;
  assign g = a & b;
  assign p = a ^ b;
  assign c1 = g[0] | (p[0] & c0);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & c0);
  assign s = p ^ {c3, c2, c1, c0};
endmodule

module cla_16bit_ripple (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
`ifdef CLA_OVERFLOW_EN
  output logic        ovf,
`endif
  output logic        cout
);
  logic [4:0] c;
  logic [15:0] s;
  assign c[0] = cin;
  for (genvar k = 0; k < 4; k++) begin : g_slice
    cla_4bit_slice u_slice (
      .a(a[4*k +: 4]),
      .b(b[4*k +: 4]),
      .c0(c[k]),
      .s(s[4*k +: 4]),
      .c4(c[k+1])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
`ifdef CLA_OVERFLOW_EN
      ovf  <= 1'b0;
`endif
    end else begin
      sum  <= s;
      cout <= c[4];
`ifdef CLA_OVERFLOW_EN
      ovf  <= (a[15] == b[15]) && (s[15] != a[15]);
`endif
    end
  end
endmodule

// File: tb/tb_cla_16bit_ripple.sv
// tb_cla_16bit_ripple: directed and random checks of the registered adder against an integer model
module tb_cla_16bit_ripple;
  logic clk = 1'b0;
  logic rst;
  logic [15:0] a, b, sum;
  logic cin, cout;
`ifdef CLA_OVERFLOW_EN
  logic ovf;
`endif
  int total = 0;
  int bad = 0;
  logic [16:0] exp_q;
  logic exp_ovf;

  always #5 clk = ~clk;

  cla_16bit_ripple dut (
    .clk(clk),
    .rst(rst),
    .a(a),
    .b(b),
    .cin(cin),
    .sum(sum),
`ifdef CLA_OVERFLOW_EN
    .ovf(ovf),
`endif
    .cout(cout)
  );

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    chk(tag, {cout, sum}, exp_q);
`ifdef CLA_OVERFLOW_EN
    chk({tag, "_ovf"}, {16'd0, ovf}, {16'd0, exp_ovf});
`endif
  endtask

  task automatic step(input logic [15:0] na, input logic [15:0] nb, input logic nc,
                      input logic nr, input string tag);
    int t;
    a = na; b = nb; cin = nc; rst = nr;
    #3;
    check_outs({tag, "_hold"});
    @(posedge clk);
    #1;
    t = int'($signed(na)) + int'($signed(nb)) + int'(nc);
    exp_q = nr ? 17'd0 : 17'(int'(na) + int'(nb) + int'(nc));
    exp_ovf = nr ? 1'b0 : (t > 32767 || t < -32768);
    check_outs(tag);
  endtask

  initial begin
    rst = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q = 17'd0;
    exp_ovf = 1'b0;
    check_outs("reset");
    step(16'd5,     16'd9,     1'b0, 1'b0, "add_5_9");
    step(16'd111,   16'd41,    1'b0, 1'b0, "add_111_41");
    step(16'd15,    16'd9,     1'b0, 1'b0, "add_15_9");
    step(16'd2,     16'd3,     1'b0, 1'b0, "add_2_3");
    step(16'h000F,  16'h0001,  1'b0, 1'b0, "ripple_s0");
    step(16'h0FFF,  16'h0001,  1'b0, 1'b0, "ripple_s2");
    step(16'hFFFF,  16'h0000,  1'b1, 1'b0, "ripple_cin");
    step(16'hFFFF,  16'hFFFF,  1'b1, 1'b0, "full_carry");
    step(16'h8000,  16'h8000,  1'b0, 1'b0, "neg_ovf");
    step(16'h7FFF,  16'h0001,  1'b0, 1'b0, "pos_ovf");
    step(16'hFFFF,  16'h0001,  1'b0, 1'b0, "wrap_no_ovf");
    step(16'h00FF,  16'h0001,  1'b0, 1'b0, "ripple_s1");
    step(16'hABCD,  16'h1234,  1'b1, 1'b1, "mid_reset");
    step(16'hABCD,  16'h1234,  1'b1, 1'b0, "resume");
    for (int i = 0; i < 10000; i++)
      step(16'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 99) == 0), "rand");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
